// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard/redirect controller.
// Drives per-stage stall holds, branch redirects (with a PEND state that keeps
// the redirect alive while IF is blocked), a sticky stall-timeout hang flag,
// and optional performance counters enabled by the macro PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int unsigned STALL_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        br_req,
  input  logic [63:0] br_target,
  output logic [5:0]  stall,
  output logic        br_e,
  output logic [63:0] br_addr,
  output logic        hang,
  output logic [31:0] perf_stall_cyc,
  output logic [31:0] perf_flush_cnt
);

  localparam int unsigned CW = (STALL_TIMEOUT < 1) ? 1 : $clog2(STALL_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_MAX = CW'(STALL_TIMEOUT);

  typedef enum logic {RUN = 1'b0, PEND = 1'b1} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [63:0]   r_redir;
  logic [CW-1:0] r_to_cnt;
  logic          r_hang;
  logic          w_accept;

  // Stall encoding: the highest requesting stage holds itself and everything
  // upstream, so the stage just below it always sees a bubble.
  always_comb begin
    stall = 6'b000000;
    if (rst_n) begin
      if (stallreq_mem)      stall = 6'b011111;
      else if (stallreq_ex)  stall = 6'b001111;
      else if (stallreq_id)  stall = 6'b000111;
      else if (stallreq_if)  stall = 6'b000011;
    end
  end

  // A branch is taken only when EX/MEM advances; a held EX keeps br_req up.
  assign w_accept = rst_n && br_req && !stall[3] && (r_state == RUN);

  // State register; a reset in PEND throws the pending redirect away.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= RUN;
    else        r_state <= w_state_nxt;
  end

  // Next state: go PEND when IF cannot take the redirect this cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:  if (w_accept && stallreq_if) w_state_nxt = PEND;
      PEND: if (!stallreq_if)            w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  // Redirect outputs: live target on accept, saved target while pending.
  always_comb begin
    br_e    = 1'b0;
    br_addr = 64'b0;
    if (rst_n) begin
      case (r_state)
        RUN: if (w_accept) begin
          br_e    = 1'b1;
          br_addr = br_target;
        end
        PEND: begin
          br_e    = 1'b1;
          br_addr = r_redir;
        end
        default: ;
      endcase
    end
  end

  // Capture the redirect target when it has to survive an IF stall.
  always_ff @(posedge clk) begin
    if (!rst_n)                       r_redir <= 64'b0;
    else if (w_accept && stallreq_if) r_redir <= br_target;
  end

  // Consecutive PC-stall counter, saturating; hang latches once it tops out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
      r_hang   <= 1'b0;
    end else begin
      if (!stall[0])               r_to_cnt <= '0;
      else if (r_to_cnt != TO_MAX) r_to_cnt <= r_to_cnt + 1'b1;
      if (stall[0] && r_to_cnt == TO_MAX) r_hang <= 1'b1;
    end
  end

  assign hang = r_hang;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;

  // Performance counters: stalled PC cycles and accepted branches, wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf_stall <= 32'b0;
      r_perf_flush <= 32'b0;
    end else begin
      if (stall[0]) r_perf_stall <= r_perf_stall + 32'd1;
      if (w_accept) r_perf_flush <= r_perf_flush + 32'd1;
    end
  end

  assign perf_stall_cyc = r_perf_stall;
  assign perf_flush_cnt = r_perf_flush;
`else
  assign perf_stall_cyc = 32'b0;
  assign perf_flush_cnt = 32'b0;
`endif

endmodule
